// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex seven-segment scanner with double-buffered value and per-slot anode blanking.
// Optional: define LEADING_ZERO_BLANK_EN to suppress segments of leading zero digits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic                    wrap;
  logic                    last;
  logic                    anode_on;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              digit_seg;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign wrap     = (prescaler == PW'(REFRESH_DIV - 1));
  assign last     = (idx == IW'(NUM_DIGITS - 1));
  assign anode_on = enable && (prescaler >= PW'(BLANK_CYCLES));

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = active[4*i +: 4];
        cur_dp  = active_dp[i];
        if (anode_on) an_next[i] = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic higher_zero;
  logic lz_blank;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    higher_zero = 1'b1;
    lz_blank    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (active[4*i +: 4] == 4'h0);
      if ((idx == IW'(i)) && (i != 0)) lz_blank = higher_zero;
    end
  end

  assign digit_seg = lz_blank ? 7'h7F : hex_decode(cur_nib);
`else
  assign digit_seg = hex_decode(cur_nib);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      pending    <= '0;
      pending_dp <= '0;
      active     <= '0;
      active_dp  <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= anode_on ? digit_seg : 7'h7F;
      dp         <= anode_on ? ~cur_dp : 1'b1;
      frame_tick <= wrap && last;
      if (wrap) begin
        prescaler <= '0;
        idx       <= last ? '0 : idx + 1'b1;
        // A load on the boundary edge bypasses the pending buffer.
        if (last) begin
          active    <= load ? value : pending;
          active_dp <= load ? dp_in : pending_dp;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (load) begin
        pending    <= value;
        pending_dp <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios then random traffic against a frame-position model.
// Honours LEADING_ZERO_BLANK_EN in the reference model.
module tb_seven_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        enable = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles since reset plus the two buffers.
  int          t = 0;
  logic [15:0] m_pending = 16'h0;
  logic [15:0] m_active = 16'h0;
  logic [3:0]  m_pdp = 4'h0;
  logic [3:0]  m_adp = 4'h0;

  logic [15:0] curVal = 16'h0;
  logic [3:0]  curDp = 4'h0;
  logic        curEn = 1'b1;

  logic [6:0] hexTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .enable    (enable),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] refSeg(input logic [15:0] v, input int d);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * d);
    nib   = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
    return hexTable[nib];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare outputs.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                               input logic [3:0] d, input logic e);
    int          pos, slot, phase;
    logic        on;
    logic [3:0]  oneHot, eAn;
    logic [6:0]  eSeg;
    logic        eDp, eTick;
    rst = r; load = l; value = v; dp_in = d; enable = e;
    @(posedge clk);
    if (r) begin
      eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1; eTick = 1'b0;
      t = 0; m_pending = 16'h0; m_active = 16'h0; m_pdp = 4'h0; m_adp = 4'h0;
    end else begin
      pos    = t % FRAME;
      slot   = pos / DIV;
      phase  = pos % DIV;
      on     = e && (phase >= BLANK);
      oneHot = 4'b0001 << slot;
      eAn    = on ? ~oneHot : 4'hF;
      eSeg   = on ? refSeg(m_active, slot) : 7'h7F;
      eDp    = on ? ~m_adp[slot] : 1'b1;
      eTick  = (pos == FRAME - 1);
      if (pos == FRAME - 1) begin
        m_active = l ? v : m_pending;
        m_adp    = l ? d : m_pdp;
      end
      if (l) begin
        m_pending = v;
        m_pdp     = d;
      end
      t++;
    end
    #1;
    checkOutput("an", {28'h0, an}, {28'h0, eAn});
    checkOutput("seg", {25'h0, seg}, {25'h0, eSeg});
    checkOutput("dp", {31'h0, dp}, {31'h0, eDp});
    checkOutput("frame_tick", {31'h0, frame_tick}, {31'h0, eTick});
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, curVal, curDp, curEn);
  endtask

  task automatic idleUntil(input int framePos);
    for (int i = 0; i < FRAME && (t % FRAME) != framePos; i++)
      applyStimulus(1'b0, 1'b0, curVal, curDp, curEn);
  endtask

  task automatic loadNow(input logic [15:0] v, input logic [3:0] d);
    curVal = v; curDp = d;
    applyStimulus(1'b0, 1'b1, v, d, curEn);
  endtask

  initial begin
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);

    loadNow(16'h1234, 4'h0);
    idleCycles(2 * FRAME);

    idleUntil(2 * DIV + 3);
    loadNow(16'hABCD, 4'h0);
    idleCycles(2 * FRAME);

    curEn = 1'b0;
    idleCycles(FRAME + 4);
    curEn = 1'b1;

    loadNow(16'h0050, 4'b0010);
    idleCycles(2 * FRAME);

    loadNow(16'h9876, 4'b1001);
    idleUntil(2 * DIV + 1);
    applyStimulus(1'b1, 1'b0, curVal, curDp, curEn);
    idleCycles(2 * FRAME);

    idleUntil(FRAME - 1);
    loadNow(16'h00FF, 4'h0);
    idleCycles(FRAME + 2);

    for (int i = 0; i < 1500; i++) begin
      logic r, l, e;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 9) != 0);
      if (l) begin
        curVal = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        curDp  = 4'($urandom);
      end
      applyStimulus(r, l, curVal, curDp, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
